// File: rtl/data_mem_handler.sv
// Single-transaction load/store bridge between the execute stage and a
// request/ack data-memory bus, with alignment checking, load extension and timeout.
module data_mem_handler #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] address,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_dat_o,
    input  logic [31:0] bus_dat_i,
    input  logic        bus_ack
);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;
    localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        cyc_q, cyc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [3:0]  sel_q, sel_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  off_q, off_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [31:0] load_data_q, load_data_d;

    logic        req;
    logic        legal;
    logic        f3_ok;
    logic        misaligned;
    logic [3:0]  sel_new;
    logic [31:0] dat_new;
    logic [31:0] lane;
    logic [31:0] load_ext;

    // Request decode: legality, lane enables and replicated store data
    always_comb begin
        req = mem_read | mem_write;
        case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok = 1'b1;
            default:                                f3_ok = 1'b0;
        endcase
        case (funct3[1:0])
            2'b01:   misaligned = address[0];
            2'b10:   misaligned = (address[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
        legal = req && !(mem_read && mem_write) && f3_ok && !misaligned
                && !(mem_write && funct3[2]);
        case (funct3[1:0])
            2'b00: begin
                sel_new = 4'b0001 << address[1:0];
                dat_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_new = 4'b0011 << address[1:0];
                dat_new = {2{store_data[15:0]}};
            end
            default: begin
                sel_new = 4'b1111;
                dat_new = store_data;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension using the latched access info
    always_comb begin
        lane = bus_dat_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
            3'b100:  load_ext = {24'b0, lane[7:0]};
            3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
            3'b101:  load_ext = {16'b0, lane[15:0]};
            default: load_ext = bus_dat_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        dat_o_d     = dat_o_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        load_data_d = load_data_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        if (state_q == STATE_IDLE) begin
            if (legal) begin
                state_d  = STATE_BUSY;
                cnt_d    = 8'd0;
                cyc_d    = 1'b1;
                we_d     = mem_write;
                adr_d    = {address[31:2], 2'b00};
                sel_d    = sel_new;
                dat_o_d  = dat_new;
                funct3_d = funct3;
                off_d    = address[1:0];
            end else if (req) begin
                err_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
            // Ack takes priority over a timeout landing on the same edge
            if (bus_ack) begin
                state_d = STATE_IDLE;
                cyc_d   = 1'b0;
                done_d  = 1'b1;
                if (!we_q) load_data_d = load_ext;
            end else if (cnt_q == CNT_LAST) begin
                state_d = STATE_IDLE;
                cyc_d   = 1'b0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= STATE_IDLE;
            cnt_q       <= 8'd0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            adr_q       <= 32'd0;
            sel_q       <= 4'd0;
            dat_o_q     <= 32'd0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            load_data_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            dat_o_q     <= dat_o_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            done_q      <= done_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
        end
    end

    // Stall is forced low while reset is asserted even if a request is pending
    assign stall     = nRst & (((state_q == STATE_IDLE) & legal) | (state_q == STATE_BUSY));
    assign done      = done_q;
    assign err       = err_q;
    assign load_data = load_data_q;
    assign bus_cyc   = cyc_q;
    assign bus_stb   = cyc_q;
    assign bus_we    = we_q;
    assign bus_adr   = adr_q;
    assign bus_sel   = sel_q;
    assign bus_dat_o = dat_o_q;

endmodule

// File: tb/tb_data_mem_handler.sv
// Directed, table-driven bench for data_mem_handler with hand-written
// sequences for timeout and mid-transaction reset.
module tb_data_mem_handler;

    logic        clk;
    logic        nRst;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        bus_cyc;
    logic        bus_stb;
    logic        bus_we;
    logic [31:0] bus_adr;
    logic [3:0]  bus_sel;
    logic [31:0] bus_dat_o;
    logic [31:0] bus_dat_i;
    logic        bus_ack;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        is_wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] dat_i;
        logic [3:0]  sel;
        logic [31:0] dat_o;
        logic [31:0] load;
        logic        is_err;
    } vec_t;

    vec_t vecs[13];

    data_mem_handler #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .nRst       (nRst),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .store_data (store_data),
        .funct3     (funct3),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .load_data  (load_data),
        .bus_cyc    (bus_cyc),
        .bus_stb    (bus_stb),
        .bus_we     (bus_we),
        .bus_adr    (bus_adr),
        .bus_sel    (bus_sel),
        .bus_dat_o  (bus_dat_o),
        .bus_dat_i  (bus_dat_i),
        .bus_ack    (bus_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] sd);
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        address    = addr;
        store_data = sd;
    endtask

    task automatic dropRequest();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'd0, 32'd0);
    endtask

    // Called at posedge+1: drives one request and walks it to completion
    task automatic runVector(input vec_t v, input int idx);
        applyStimulus(!v.is_wr, v.is_wr, v.f3, v.addr, v.sd);
        bus_ack = 1'b0;
        #1;
        checkOutput($sformatf("v%0d_stall_req", idx), 32'(stall), v.is_err ? 32'd0 : 32'd1);
        @(posedge clk); #1;
        if (v.is_err) begin
            checkOutput($sformatf("v%0d_err", idx), 32'(err), 32'd1);
            checkOutput($sformatf("v%0d_nocyc", idx), 32'(bus_cyc), 32'd0);
            checkOutput($sformatf("v%0d_nodone", idx), 32'(done), 32'd0);
            dropRequest();
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_err_clr", idx), 32'(err), 32'd0);
        end else begin
            checkOutput($sformatf("v%0d_cyc", idx), 32'(bus_cyc), 32'd1);
            checkOutput($sformatf("v%0d_stb", idx), 32'(bus_stb), 32'd1);
            checkOutput($sformatf("v%0d_we", idx), 32'(bus_we), 32'(v.is_wr));
            checkOutput($sformatf("v%0d_adr", idx), bus_adr, {v.addr[31:2], 2'b00});
            checkOutput($sformatf("v%0d_sel", idx), 32'(bus_sel), 32'(v.sel));
            if (v.is_wr) checkOutput($sformatf("v%0d_dat_o", idx), bus_dat_o, v.dat_o);
            checkOutput($sformatf("v%0d_stall_busy", idx), 32'(stall), 32'd1);
            bus_ack   = 1'b1;
            bus_dat_i = v.dat_i;
            @(posedge clk); #1;
            bus_ack   = 1'b0;
            bus_dat_i = 32'd0;
            dropRequest();
            #1;
            checkOutput($sformatf("v%0d_done", idx), 32'(done), 32'd1);
            checkOutput($sformatf("v%0d_noerr", idx), 32'(err), 32'd0);
            checkOutput($sformatf("v%0d_cyc_clr", idx), 32'(bus_cyc), 32'd0);
            checkOutput($sformatf("v%0d_stall_clr", idx), 32'(stall), 32'd0);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_done_clr", idx), 32'(done), 32'd0);
        end
        checkOutput($sformatf("v%0d_load", idx), load_data, v.load);
    endtask

    initial begin
        //             wr    f3      addr         sd            dat_i         sel      dat_o         load          err
        vecs[0]  = '{1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[1]  = '{1'b0, 3'b000, 32'h103, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 3'b100, 32'h103, 32'h0,        32'h80FFFFFF, 4'b1000, 32'h0,        32'h00000080, 1'b0};
        vecs[3]  = '{1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0,        4'b1100, 32'hABCDABCD, 32'h00000080, 1'b0};
        vecs[4]  = '{1'b0, 3'b001, 32'h102, 32'h0,        32'h80017FFF, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        vecs[5]  = '{1'b0, 3'b101, 32'h100, 32'h0,        32'h8001F00F, 4'b0011, 32'h0,        32'h0000F00F, 1'b0};
        vecs[6]  = '{1'b1, 3'b000, 32'h301, 32'h000000A5, 32'h0,        4'b0010, 32'hA5A5A5A5, 32'h0000F00F, 1'b0};
        vecs[7]  = '{1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h0,        4'b1111, 32'hCAFEF00D, 32'h0000F00F, 1'b0};
        vecs[8]  = '{1'b0, 3'b010, 32'h101, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000F00F, 1'b1};
        vecs[9]  = '{1'b0, 3'b001, 32'h103, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000F00F, 1'b1};
        vecs[10] = '{1'b1, 3'b100, 32'h200, 32'h11,       32'h0,        4'b0000, 32'h0,        32'h0000F00F, 1'b1};
        vecs[11] = '{1'b0, 3'b011, 32'h200, 32'h0,        32'h0,        4'b0000, 32'h0,        32'h0000F00F, 1'b1};
        vecs[12] = '{1'b0, 3'b000, 32'h001, 32'h0,        32'h00007F00, 4'b0010, 32'h0,        32'h0000007F, 1'b0};

        nRst      = 1'b0;
        bus_ack   = 1'b0;
        bus_dat_i = 32'd0;
        dropRequest();
        #12;
        checkOutput("rst_stall", 32'(stall), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_load", load_data, 32'd0);
        checkOutput("rst_cyc", 32'(bus_cyc), 32'd0);
        checkOutput("rst_sel", 32'(bus_sel), 32'd0);
        nRst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) runVector(vecs[i], i);

        // Simultaneous read and write is rejected without a bus cycle
        applyStimulus(1'b1, 1'b1, 3'b010, 32'h100, 32'h5);
        #1;
        checkOutput("rw_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        checkOutput("rw_err", 32'(err), 32'd1);
        checkOutput("rw_nocyc", 32'(bus_cyc), 32'd0);
        dropRequest();
        @(posedge clk); #1;

        // Timeout: with TIMEOUT=4 the cycle stays open four cycles then aborts
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h600, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checkOutput($sformatf("to_cyc%0d", c), 32'(bus_cyc), 32'd1);
            checkOutput($sformatf("to_noerr%0d", c), 32'(err), 32'd0);
        end
        @(posedge clk); #1;
        dropRequest();
        checkOutput("to_err", 32'(err), 32'd1);
        checkOutput("to_nodone", 32'(done), 32'd0);
        checkOutput("to_cyc_clr", 32'(bus_cyc), 32'd0);
        checkOutput("to_load_hold", load_data, 32'h0000007F);
        @(posedge clk); #1;
        checkOutput("to_err_clr", 32'(err), 32'd0);

        // Reset in the middle of a bus cycle, then a stray ack
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h500, 32'd0);
        @(posedge clk); #1;
        checkOutput("rb_cyc", 32'(bus_cyc), 32'd1);
        #2;
        nRst = 1'b0;
        #1;
        checkOutput("rb_cyc0", 32'(bus_cyc), 32'd0);
        checkOutput("rb_stb0", 32'(bus_stb), 32'd0);
        checkOutput("rb_stall0", 32'(stall), 32'd0);
        checkOutput("rb_load0", load_data, 32'd0);
        dropRequest();
        #2;
        nRst      = 1'b1;
        bus_ack   = 1'b1;
        bus_dat_i = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        checkOutput("rb_nodone", 32'(done), 32'd0);
        checkOutput("rb_nocyc", 32'(bus_cyc), 32'd0);
        checkOutput("rb_load", load_data, 32'd0);
        @(posedge clk); #1;
        checkOutput("rb_nodone2", 32'(done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
